// File: rtl/audio_in_deserializer.sv
// rtl/audio_in_deserializer.sv - ADC serial-to-parallel capture with paired L/R show-ahead FIFOs
// Words are captured MSB-first per LRCK half-frame; only complete left+right pairs are queued.

module audio_in_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W:1]   wr_data,
    input  logic         rd_en,
    output logic [W:1]   rd_data,
    output logic         full,
    output logic [7:0]   read_available
);
    logic [W:1] mem [0:127];
    logic [W:1] last_q;
    logic [6:0] wr_ptr;
    logic [6:0] rd_ptr;
    logic       full_q;
    logic       empty;
    logic       pop;

    assign empty   = (wr_ptr == rd_ptr) && !full_q;
    assign pop     = rd_en && !empty;
    assign full    = full_q;
    // When empty, keep presenting the last word that was popped
    assign rd_data = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            full_q         <= 1'b0;
            last_q         <= '0;
            read_available <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 7'd1;
            if (pop) begin
                rd_ptr <= rd_ptr + 7'd1;
                last_q <= mem[rd_ptr];
            end
            if (wr_en && !pop)
                full_q <= ((wr_ptr + 7'd1) == rd_ptr);
            else if (pop && !wr_en)
                full_q <= 1'b0;
            read_available <= {full_q, wr_ptr - rd_ptr};
        end
    end
endmodule

module audio_in_deserializer #(
    parameter int AUDIO_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bit_clk_rising_edge,
    input  logic                      bit_clk_falling_edge,
    input  logic                      left_right_clk_rising_edge,
    input  logic                      left_right_clk_falling_edge,
    input  logic                      serial_audio_in_data,
    input  logic                      read_left_channel_en,
    input  logic                      read_right_channel_en,
    output logic [AUDIO_DATA_WIDTH:1] left_channel_data,
    output logic [AUDIO_DATA_WIDTH:1] right_channel_data,
    output logic [7:0]                left_channel_fifo_read_available,
    output logic [7:0]                right_channel_fifo_read_available,
    output logic                      pair_dropped
);
    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    logic [W:1]    shift_reg;
    logic [CW-1:0] bit_count;
    logic [W:1]    left_hold;
    logic          left_valid;
    logic          seen_rise;
    logic          pair_valid;
    logic [W:1]    pair_left;
    logic [W:1]    pair_right;
    logic          left_full;
    logic          right_full;
    logic          accept;
    logic          unused_inputs;

    assign unused_inputs = bit_clk_falling_edge;
    assign accept        = pair_valid && !left_full && !right_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg    <= '0;
            bit_count    <= '0;
            left_hold    <= '0;
            left_valid   <= 1'b0;
            seen_rise    <= 1'b0;
            pair_valid   <= 1'b0;
            pair_left    <= '0;
            pair_right   <= '0;
            pair_dropped <= 1'b0;
        end else begin
            pair_valid   <= 1'b0;
            pair_dropped <= pair_valid && !accept;
            if (left_right_clk_rising_edge) begin
                shift_reg <= '0;
                bit_count <= '0;
                seen_rise <= 1'b1;
                // A pair forms only if a left word was framed by a real rise->fall
                if (left_valid) begin
                    pair_valid <= 1'b1;
                    pair_left  <= left_hold;
                    pair_right <= shift_reg;
                end
                left_valid <= 1'b0;
            end else if (left_right_clk_falling_edge) begin
                shift_reg  <= '0;
                bit_count  <= '0;
                seen_rise  <= 1'b0;
                left_valid <= seen_rise;
                if (seen_rise)
                    left_hold <= shift_reg;
            end else if (bit_clk_rising_edge && (bit_count < CW'(W))) begin
                for (int i = 1; i <= W; i++) begin
                    if (bit_count == CW'(W - i))
                        shift_reg[i] <= serial_audio_in_data;
                end
                bit_count <= bit_count + CW'(1);
            end
        end
    end

    audio_in_fifo #(.W(W)) u_left_fifo (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (accept),
        .wr_data        (pair_left),
        .rd_en          (read_left_channel_en),
        .rd_data        (left_channel_data),
        .full           (left_full),
        .read_available (left_channel_fifo_read_available)
    );

    audio_in_fifo #(.W(W)) u_right_fifo (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (accept),
        .wr_data        (pair_right),
        .rd_en          (read_right_channel_en),
        .rd_data        (right_channel_data),
        .full           (right_full),
        .read_available (right_channel_fifo_read_available)
    );
endmodule

// File: tb/tb_audio_in_deserializer.sv
// tb/tb_audio_in_deserializer.sv - directed self-checking bench for audio_in_deserializer (W=8)
module tb_audio_in_deserializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         bclk_r = 1'b0, bclk_f = 1'b0, lr_r = 1'b0, lr_f = 1'b0, sdata = 1'b0;
    logic         rd_l = 1'b0, rd_r = 1'b0;
    logic [W:1]   l_data, r_data;
    logic [7:0]   l_av, r_av;
    logic         dropped;
    int           n_checks = 0;
    int           n_fail = 0;
    int           drop_count = 0;

    audio_in_deserializer #(.AUDIO_DATA_WIDTH(W)) dut (
        .clk                               (clk),
        .reset                             (reset),
        .bit_clk_rising_edge               (bclk_r),
        .bit_clk_falling_edge              (bclk_f),
        .left_right_clk_rising_edge        (lr_r),
        .left_right_clk_falling_edge       (lr_f),
        .serial_audio_in_data              (sdata),
        .read_left_channel_en              (rd_l),
        .read_right_channel_en             (rd_r),
        .left_channel_data                 (l_data),
        .right_channel_data                (r_data),
        .left_channel_fifo_read_available  (l_av),
        .right_channel_fifo_read_available (r_av),
        .pair_dropped                      (dropped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dropped === 1'b1) drop_count++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task cyc();
        @(posedge clk);
        #1;
        bclk_r = 1'b0; lr_r = 1'b0; lr_f = 1'b0; rd_l = 1'b0; rd_r = 1'b0;
    endtask

    task bit_in(input logic b);
        bclk_r = 1'b1; sdata = b; cyc();
    endtask

    task word_in(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
    endtask

    task rise();     lr_r = 1'b1; cyc(); endtask
    task fall();     lr_f = 1'b1; cyc(); endtask
    task pop_both(); rd_l = 1'b1; rd_r = 1'b1; cyc(); endtask

    task send_pair(input logic [7:0] l, input logic [7:0] r);
        word_in({8'h00, l}, 8); fall(); word_in({8'h00, r}, 8); rise();
    endtask

    task test_reset();
        reset = 1'b1; cyc(); cyc();
        n_checks++; if (l_data !== 8'h00) begin n_fail++; $display("FAIL reset_l_data got %h want 00", l_data); end
        n_checks++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL reset_r_data got %h want 00", r_data); end
        n_checks++; if (l_av !== 8'd0) begin n_fail++; $display("FAIL reset_l_av got %0d want 0", l_av); end
        n_checks++; if (r_av !== 8'd0) begin n_fail++; $display("FAIL reset_r_av got %0d want 0", r_av); end
        n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got %b want 0", dropped); end
        reset = 1'b0; cyc();
    endtask

    task test_basic();
        rise(); word_in(16'hA5, 8); fall(); word_in(16'h3C, 8); rise();
        n_checks++; if (l_av !== 8'd0) begin n_fail++; $display("FAIL basic_av_t0 got %0d want 0", l_av); end
        cyc();
        n_checks++; if (l_av !== 8'd0) begin n_fail++; $display("FAIL basic_av_t1 got %0d want 0", l_av); end
        cyc();
        n_checks++; if (l_av !== 8'd1) begin n_fail++; $display("FAIL basic_l_av_t2 got %0d want 1", l_av); end
        n_checks++; if (r_av !== 8'd1) begin n_fail++; $display("FAIL basic_r_av_t2 got %0d want 1", r_av); end
        n_checks++; if (l_data !== 8'hA5) begin n_fail++; $display("FAIL basic_l_data got %h want a5", l_data); end
        n_checks++; if (r_data !== 8'h3C) begin n_fail++; $display("FAIL basic_r_data got %h want 3c", r_data); end
        pop_both(); cyc();
        n_checks++; if (l_av !== 8'd0) begin n_fail++; $display("FAIL basic_drain_av got %0d want 0", l_av); end
        n_checks++; if (l_data !== 8'hA5) begin n_fail++; $display("FAIL basic_hold_l got %h want a5", l_data); end
    endtask

    task test_short_long();
        word_in(16'b10110, 5); fall(); word_in(16'h096F, 12); rise(); cyc(); cyc();
        n_checks++; if (l_data !== 8'hB0) begin n_fail++; $display("FAIL short_l_data got %h want b0", l_data); end
        n_checks++; if (r_data !== 8'h96) begin n_fail++; $display("FAIL long_r_data got %h want 96", r_data); end
        n_checks++; if (r_av !== 8'd1) begin n_fail++; $display("FAIL short_long_av got %0d want 1", r_av); end
        pop_both(); cyc();
    endtask

    task test_startup();
        reset = 1'b1; cyc(); reset = 1'b0;
        word_in(16'hF, 4); fall(); word_in(16'hEE, 8); rise(); cyc(); cyc();
        n_checks++; if (l_av !== 8'd0) begin n_fail++; $display("FAIL startup_no_write got %0d want 0", l_av); end
        send_pair(8'h11, 8'h22); cyc(); cyc();
        n_checks++; if (l_av !== 8'd1) begin n_fail++; $display("FAIL startup_first_av got %0d want 1", l_av); end
        n_checks++; if (l_data !== 8'h11) begin n_fail++; $display("FAIL startup_l_data got %h want 11", l_data); end
        n_checks++; if (r_data !== 8'h22) begin n_fail++; $display("FAIL startup_r_data got %h want 22", r_data); end
        pop_both(); cyc();
    endtask

    task test_full();
        logic [7:0] b;
        for (int i = 0; i < 128; i++) begin
            b = 8'(i);
            send_pair(b, ~b);
        end
        cyc(); cyc();
        n_checks++; if (l_av !== 8'h80) begin n_fail++; $display("FAIL full_l_av got %h want 80", l_av); end
        n_checks++; if (r_av !== 8'h80) begin n_fail++; $display("FAIL full_r_av got %h want 80", r_av); end
        n_checks++; if (drop_count !== 0) begin n_fail++; $display("FAIL full_no_drop got %0d want 0", drop_count); end
        send_pair(8'h77, 8'h88); cyc();
        n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL drop_pulse got %b want 1", dropped); end
        cyc();
        n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_end got %b want 0", dropped); end
        n_checks++; if (drop_count !== 1) begin n_fail++; $display("FAIL drop_count got %0d want 1", drop_count); end
        n_checks++; if (l_av !== 8'h80) begin n_fail++; $display("FAIL drop_av got %h want 80", l_av); end
        n_checks++; if (l_data !== 8'h00) begin n_fail++; $display("FAIL drop_l_head got %h want 00", l_data); end
        n_checks++; if (r_data !== 8'hFF) begin n_fail++; $display("FAIL drop_r_head got %h want ff", r_data); end
    endtask

    task test_concurrency();
        for (int i = 0; i < 123; i++) pop_both();
        cyc();
        n_checks++; if (l_av !== 8'd5) begin n_fail++; $display("FAIL conc_pre_av got %0d want 5", l_av); end
        n_checks++; if (l_data !== 8'h7B) begin n_fail++; $display("FAIL conc_pre_l got %h want 7b", l_data); end
        word_in(16'h5A, 8); fall(); word_in(16'h5B, 8); rise();
        pop_both(); cyc();
        n_checks++; if (l_av !== 8'd5) begin n_fail++; $display("FAIL conc_l_av got %0d want 5", l_av); end
        n_checks++; if (r_av !== 8'd5) begin n_fail++; $display("FAIL conc_r_av got %0d want 5", r_av); end
        n_checks++; if (l_data !== 8'h7C) begin n_fail++; $display("FAIL conc_l_head got %h want 7c", l_data); end
        n_checks++; if (r_data !== 8'h83) begin n_fail++; $display("FAIL conc_r_head got %h want 83", r_data); end
        for (int i = 0; i < 4; i++) pop_both();
        n_checks++; if (l_data !== 8'h5A) begin n_fail++; $display("FAIL conc_new_l got %h want 5a", l_data); end
        n_checks++; if (r_data !== 8'h5B) begin n_fail++; $display("FAIL conc_new_r got %h want 5b", r_data); end
        pop_both(); pop_both(); cyc();
        n_checks++; if (l_av !== 8'd0) begin n_fail++; $display("FAIL empty_read_av got %0d want 0", l_av); end
        n_checks++; if (l_data !== 8'h5A) begin n_fail++; $display("FAIL empty_read_hold got %h want 5a", l_data); end
    endtask

    task test_priority_reset();
        word_in(16'h7F, 7);
        lr_f = 1'b1; bclk_r = 1'b1; sdata = 1'b1; cyc();
        word_in(16'h81, 8);
        lr_r = 1'b1; bclk_r = 1'b1; sdata = 1'b1; cyc();
        cyc(); cyc();
        n_checks++; if (l_data !== 8'hFE) begin n_fail++; $display("FAIL prio_l_data got %h want fe", l_data); end
        n_checks++; if (r_data !== 8'h81) begin n_fail++; $display("FAIL prio_r_data got %h want 81", r_data); end
        word_in(16'hF, 4);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (l_data !== 8'h00) begin n_fail++; $display("FAIL areset_l_data got %h want 00", l_data); end
        n_checks++; if (r_data !== 8'h00) begin n_fail++; $display("FAIL areset_r_data got %h want 00", r_data); end
        n_checks++; if (l_av !== 8'd0) begin n_fail++; $display("FAIL areset_l_av got %0d want 0", l_av); end
        n_checks++; if (r_av !== 8'd0) begin n_fail++; $display("FAIL areset_r_av got %0d want 0", r_av); end
        cyc(); reset = 1'b0;
        word_in(16'hF, 4); fall(); word_in(16'h33, 8); rise(); cyc(); cyc();
        n_checks++; if (l_av !== 8'd0) begin n_fail++; $display("FAIL stale_av got %0d want 0", l_av); end
        n_checks++; if (l_data !== 8'h00) begin n_fail++; $display("FAIL stale_l_data got %h want 00", l_data); end
        send_pair(8'h42, 8'h24); cyc(); cyc();
        n_checks++; if (l_data !== 8'h42) begin n_fail++; $display("FAIL recover_l got %h want 42", l_data); end
        n_checks++; if (r_data !== 8'h24) begin n_fail++; $display("FAIL recover_r got %h want 24", r_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_long();
        test_startup();
        test_full();
        test_concurrency();
        test_priority_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
